channel_in_acc_tree: RTL and testbench
======================================

CHANNEL_IN_ACC_TREE -- requirements
Module: channel_in_acc_tree

Interface
REQ-001 The module SHALL have parameter CHANNEL_IN_NUM, default 8: input channels summed per beat; power of two, 2..64.
REQ-002 The module SHALL have parameter PICTURE_NUM, default 4: independent SIMD lanes.
REQ-003 The module SHALL have parameter WIDTH_IN, default 16: signed two's-complement width of each input element.
REQ-004 The module SHALL have parameter WIDTH_OUT, default 32: signed accumulator/output element width; WIDTH_OUT >= WIDTH_IN + log2(CHANNEL_IN_NUM).
REQ-005 The module SHALL have parameter OUT_DELAY, default 4: output alignment register stages, 0..7.
REQ-006 The module SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-007 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 The module SHALL have port in_valid, input, 1 bit: data_in beat is valid.
REQ-009 The module SHALL have port in_first, input, 1 bit: beat starts a new accumulation; qualified by in_valid.
REQ-010 The module SHALL have port in_last, input, 1 bit: beat ends the accumulation; qualified by in_valid.
REQ-011 The module SHALL have port data_in, input, CHANNEL_IN_NUM*PICTURE_NUM*WIDTH_IN bits: channel c, lane p at bit offset (c*PICTURE_NUM+p)*WIDTH_IN.
REQ-012 The module SHALL have port out_valid, output, 1 bit: one-cycle pulse marking a completed accumulation on data_out.
REQ-013 The module SHALL have port data_out, output, PICTURE_NUM*WIDTH_OUT bits: lane p at bit offset p*WIDTH_OUT.

Function
REQ-014 The adder tree SHALL have L = log2(CHANNEL_IN_NUM) registered stages; stage s adds adjacent pairs (2i, 2i+1) lane-wise, with sign extension and width growth of 1 bit per stage.
REQ-015 in_valid, in_first and in_last SHALL be carried through the tree in a valid/flag shift pipeline exactly aligned with the data.
REQ-016 The accumulator stage (1 cycle) SHALL, per lane on an aligned valid beat, load the sign-extended tree sum when first=1 and add it to the held value when first=0.
REQ-017 The accumulator SHALL hold its value on cycles with no aligned valid beat (bubbles); bubbles anywhere SHALL NOT alter results.
REQ-018 An aligned valid beat with last=1 SHALL produce a result-valid for the post-update accumulator value; with first=last=1 the result SHALL be the single-beat sum.
REQ-019 A beat with first=0 and no prior first since reset SHALL accumulate onto the current value (0 after reset).
REQ-020 The result and its valid SHALL pass through OUT_DELAY register stages; with OUT_DELAY=0, data_out and out_valid SHALL be the accumulator-stage registers.
REQ-021 Latency from the in_valid beat carrying in_last to out_valid SHALL be exactly L+1+OUT_DELAY cycles (default 8).
REQ-022 data_out SHALL hold the last result between out_valid pulses.
REQ-023 The block SHALL accept one beat per cycle with no backpressure; back-to-back groups (last followed immediately by first) SHALL be supported.

Reset
REQ-024 While rst_n=0, all tree, flag, accumulator and delay registers SHALL clear asynchronously to 0; out_valid=0 and data_out=0.
REQ-025 Reset asserted mid-accumulation SHALL discard in-flight beats; no out_valid SHALL be produced for them after release.
REQ-026 The first rising clk edge after rst_n deasserts SHALL operate normally.

Configuration
REQ-027 With macro CHANNEL_ACC_SAT_EN defined, each accumulator update SHALL saturate to [-2^(WIDTH_OUT-1), 2^(WIDTH_OUT-1)-1] per lane.
REQ-028 Without CHANNEL_ACC_SAT_EN, accumulator updates SHALL wrap modulo 2^WIDTH_OUT.

Verification
REQ-029 Single beat, defaults, all 32 elements = 1, first=last=1 -> out_valid pulse 8 cycles later; every lane = 8.
REQ-030 Three beats, lane 0 channels = 1, 2, 3 respectively, first on beat 0, last on beat 2, one bubble between beats 1 and 2 -> one out_valid; lane 0 = 8+16+24 = 48.
REQ-031 Mixed signs: channel c lane p = (c even ? +100 : -100), first=last=1 -> every lane = 0.
REQ-032 WIDTH_OUT=20, repeated beats of all elements = 32767 with first only on the first beat -> with CHANNEL_ACC_SAT_EN, clamps at 524287; without it, wraps to the modulo-2^20 value.
REQ-033 rst_n pulsed low between beats 1 and 2 of a 3-beat group -> no out_valid for that group; the next first=last=1 group with all elements = 2 -> every lane = 16.
REQ-034 CHANNEL_IN_NUM=2, OUT_DELAY=0, back-to-back first=last beats -> out_valid high 2 cycles after each beat on consecutive cycles with correct per-beat sums.

Source files
------------

// File: rtl/channel_in_acc_tree.sv
// Pipelined per-lane channel adder tree feeding a first/last-framed accumulator and output delay.
// Define CHANNEL_ACC_SAT_EN to saturate accumulator updates instead of wrapping.

module channel_in_acc_tree #(
  parameter int CHANNEL_IN_NUM = 8,
  parameter int PICTURE_NUM    = 4,
  parameter int WIDTH_IN       = 16,
  parameter int WIDTH_OUT      = 32,
  parameter int OUT_DELAY      = 4
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         in_valid,
  input  logic                                         in_first,
  input  logic                                         in_last,
  input  logic [CHANNEL_IN_NUM*PICTURE_NUM*WIDTH_IN-1:0] data_in,
  output logic                                         out_valid,
  output logic [PICTURE_NUM*WIDTH_OUT-1:0]             data_out
);

  localparam int L  = $clog2(CHANNEL_IN_NUM);
  localparam int TW = WIDTH_IN + L;
  localparam int PW = PICTURE_NUM * WIDTH_OUT;

  // Bit offset of tree level s (1..L) inside the flattened tree register; level s is
  // (CHANNEL_IN_NUM >> s) * PICTURE_NUM elements of WIDTH_IN + s bits each.
  function automatic int lvl_off(input int s);
    int off = 0;
    for (int k = 1; k < s; k++) begin
      off += (CHANNEL_IN_NUM >> k) * PICTURE_NUM * (WIDTH_IN + k);
    end
    return off;
  endfunction

  localparam int TREE_BITS = lvl_off(L + 1);
  localparam int ROOT_OFF  = lvl_off(L);

  logic [TREE_BITS-1:0] tree_d, tree_q;
  logic [L:1]           vld_q, fst_q, lst_q;

  for (genvar s = 1; s <= L; s++) begin : g_stage
    localparam int N   = CHANNEL_IN_NUM >> s;
    localparam int SW  = WIDTH_IN + s;
    localparam int OFF = lvl_off(s);
    localparam int POF = lvl_off(s - 1);
    for (genvar i = 0; i < N; i++) begin : g_pair
      for (genvar p = 0; p < PICTURE_NUM; p++) begin : g_lane
        logic [SW-2:0] a, b;
        if (s == 1) begin : g_leaf
          assign a = data_in[((2*i)*PICTURE_NUM+p)*WIDTH_IN +: WIDTH_IN];
          assign b = data_in[((2*i+1)*PICTURE_NUM+p)*WIDTH_IN +: WIDTH_IN];
        end else begin : g_node
          assign a = tree_q[POF + ((2*i)*PICTURE_NUM+p)*(SW-1) +: SW-1];
          assign b = tree_q[POF + ((2*i+1)*PICTURE_NUM+p)*(SW-1) +: SW-1];
        end
        assign tree_d[OFF + (i*PICTURE_NUM+p)*SW +: SW] = {a[SW-2], a} + {b[SW-2], b};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tree_q <= '0;
      vld_q  <= '0;
      fst_q  <= '0;
      lst_q  <= '0;
    end else begin
      tree_q   <= tree_d;
      vld_q[1] <= in_valid;
      fst_q[1] <= in_first;
      lst_q[1] <= in_last;
      for (int k = 2; k <= L; k++) begin
        vld_q[k] <= vld_q[k-1];
        fst_q[k] <= fst_q[k-1];
        lst_q[k] <= lst_q[k-1];
      end
    end
  end

  // Accumulator stage: acc_q is the running sum, res_q captures it on the closing beat so the
  // output holds between results even while the next group accumulates.
  logic [PW-1:0] acc_d, acc_q, res_d, res_q;
  logic          beat_last, res_vld_q;

  assign beat_last = vld_q[L] & lst_q[L];

  for (genvar p = 0; p < PICTURE_NUM; p++) begin : g_acc
    logic signed [WIDTH_OUT-1:0] root_ext, cur, nxt;
    assign root_ext = WIDTH_OUT'($signed(tree_q[ROOT_OFF + p*TW +: TW]));
    // A first beat loads, which is the same as adding onto zero.
    assign cur = fst_q[L] ? '0 : $signed(acc_q[p*WIDTH_OUT +: WIDTH_OUT]);
`ifdef CHANNEL_ACC_SAT_EN
    logic signed [WIDTH_OUT:0] wide;
    assign wide = {cur[WIDTH_OUT-1], cur} + {root_ext[WIDTH_OUT-1], root_ext};
    always_comb begin
      nxt = wide[WIDTH_OUT-1:0];
      if (wide[WIDTH_OUT] != wide[WIDTH_OUT-1]) begin
        nxt = wide[WIDTH_OUT] ? {1'b1, {(WIDTH_OUT-1){1'b0}}} : {1'b0, {(WIDTH_OUT-1){1'b1}}};
      end
    end
`else
    assign nxt = cur + root_ext;
`endif
    assign acc_d[p*WIDTH_OUT +: WIDTH_OUT] = vld_q[L] ? nxt : acc_q[p*WIDTH_OUT +: WIDTH_OUT];
    assign res_d[p*WIDTH_OUT +: WIDTH_OUT] = beat_last ? nxt : res_q[p*WIDTH_OUT +: WIDTH_OUT];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      res_q     <= '0;
      res_vld_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      res_q     <= res_d;
      res_vld_q <= beat_last;
    end
  end

  if (OUT_DELAY == 0) begin : g_nodly
    assign data_out  = res_q;
    assign out_valid = res_vld_q;
  end else begin : g_dly
    logic [PW-1:0]        dly_q [OUT_DELAY];
    logic [OUT_DELAY-1:0] dv_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < OUT_DELAY; k++) dly_q[k] <= '0;
        dv_q <= '0;
      end else begin
        dly_q[0] <= res_q;
        dv_q[0]  <= res_vld_q;
        for (int k = 1; k < OUT_DELAY; k++) begin
          dly_q[k] <= dly_q[k-1];
          dv_q[k]  <= dv_q[k-1];
        end
      end
    end

    assign data_out  = dly_q[OUT_DELAY-1];
    assign out_valid = dv_q[OUT_DELAY-1];
  end

endmodule

// File: tb/tb_channel_in_acc_tree.sv
// Bench: default, WIDTH_OUT=20 and CHANNEL_IN_NUM=2/OUT_DELAY=0 instances on shared stimulus,
// checked cycle-by-cycle against an integer arithmetic model plus directed table results.

module tb_channel_in_acc_tree;
  localparam int P = 4;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_first, in_last;
  logic [511:0] din;
  logic         ov8, ov20, ov2;
  logic [127:0] dout8, dout2;
  logic [79:0]  dout20;

  channel_in_acc_tree dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .data_in(din), .out_valid(ov8), .data_out(dout8)
  );

  channel_in_acc_tree #(.WIDTH_OUT(20)) dut20 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .data_in(din), .out_valid(ov20), .data_out(dout20)
  );

  channel_in_acc_tree #(.CHANNEL_IN_NUM(2), .OUT_DELAY(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .data_in(din[127:0]), .out_valid(ov2), .data_out(dout2)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    longint            due;
    logic [3:0][63:0]  v;
  } exp_t;

  typedef struct packed {
    bit     v;
    bit     f;
    bit     l;
    int     kind;
    int     val;
    bit     chk;
    longint exp;
  } rec_t;

  exp_t   q8[$], q20[$], q2[$];
  longint acc8[4], acc20[4], acc2[4];
  longint last_exp[3][4];
  longint res8[$], res20[$];
  int     total = 0, bad = 0, pulses8 = 0;
  bit     sat_en;
  rec_t   tbl[11];

  function automatic longint upd(input longint acc, input longint s, input bit f, input int w);
    longint n, half;
    half = longint'(1) << (w - 1);
    n = f ? s : acc + s;
    if (sat_en) begin
      if (n > half - 1) n = half - 1;
      if (n < -half) n = -half;
    end else begin
      n = n & ((half << 1) - 1);
      if (n >= half) n = n - (half << 1);
    end
    return n;
  endfunction

  function automatic logic [511:0] mk(input int kind, input int val);
    logic [511:0] d = '0;
    int e;
    for (int c = 0; c < 8; c++) begin
      for (int p = 0; p < P; p++) begin
        if (kind == 0) e = val;
        else if (kind == 1) e = (p == 0) ? val : 0;
        else e = (c % 2 == 0) ? val : -val;
        d[(c*P+p)*W +: W] = e[15:0];
      end
    end
    return d;
  endfunction

  task automatic model_clear();
    for (int p = 0; p < 4; p++) begin
      acc8[p] = 0; acc20[p] = 0; acc2[p] = 0;
      for (int k = 0; k < 3; k++) last_exp[k][p] = 0;
    end
    q8.delete(); q20.delete(); q2.delete();
  endtask

  task automatic model_update(input bit f, input bit l, input logic [511:0] d);
    exp_t e8, e20, e2;
    longint s8, s2, el;
    for (int p = 0; p < P; p++) begin
      s8 = 0; s2 = 0;
      for (int c = 0; c < 8; c++) begin
        el = longint'($signed(d[(c*P+p)*W +: W]));
        s8 += el;
        if (c < 2) s2 += el;
      end
      acc8[p]  = upd(acc8[p], s8, f, 32);
      acc20[p] = upd(acc20[p], s8, f, 20);
      acc2[p]  = upd(acc2[p], s2, f, 32);
      e8.v[p] = acc8[p]; e20.v[p] = acc20[p]; e2.v[p] = acc2[p];
    end
    if (l) begin
      e8.due = cyc + 8; e20.due = cyc + 8; e2.due = cyc + 2;
      q8.push_back(e8); q20.push_back(e20); q2.push_back(e2);
    end
  endtask

  // One input cycle; also releases reset so the first edge after release takes a beat.
  task automatic beat(input bit v, input bit f, input bit l, input logic [511:0] d);
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_valid = v; in_first = f; in_last = l; din = d;
    if (v) model_update(f, l, d);
  endtask

  function automatic logic [511:0] rnd_data();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 1'($urandom), 1'($urandom), rnd_data());
  endtask

  task automatic check_zero(input string nm);
    total++;
    if (ov8 !== 1'b0 || dout8 !== '0) begin
      bad++; $display("FAIL %s dut8 got ov=%0b data=%h want 0", nm, ov8, dout8);
    end
    total++;
    if (ov20 !== 1'b0 || dout20 !== '0) begin
      bad++; $display("FAIL %s dut20 got ov=%0b data=%h want 0", nm, ov20, dout20);
    end
    total++;
    if (ov2 !== 1'b0 || dout2 !== '0) begin
      bad++; $display("FAIL %s dut2 got ov=%0b data=%h want 0", nm, ov2, dout2);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    model_clear();
    #1;
    check_zero("reset_async");
    repeat (2) @(posedge clk);
  endtask

  task automatic check_out(input int id, input string nm, input logic ov,
                           input logic [3:0][63:0] got, input bit hit, input exp_t e);
    longint want;
    total++;
    if (ov !== hit) begin
      bad++; $display("FAIL %s out_valid cyc=%0d got=%0b want=%0b", nm, cyc, ov, hit);
    end
    for (int p = 0; p < P; p++) begin
      want = hit ? longint'(e.v[p]) : last_exp[id][p];
      total++;
      if (longint'(got[p]) != want) begin
        bad++;
        $display("FAIL %s lane%0d cyc=%0d got=%0d want=%0d", nm, p, cyc, longint'(got[p]), want);
      end
    end
    if (hit) for (int p = 0; p < P; p++) last_exp[id][p] = longint'(e.v[p]);
  endtask

  always @(negedge clk) begin
    logic [3:0][63:0] g8, g20, g2;
    exp_t e;
    bit   hit;
    for (int p = 0; p < P; p++) begin
      g8[p]  = 64'(longint'($signed(dout8[p*32 +: 32])));
      g20[p] = 64'(longint'($signed(dout20[p*20 +: 20])));
      g2[p]  = 64'(longint'($signed(dout2[p*32 +: 32])));
    end
    e = '0;
    hit = (q8.size() > 0) && (q8[0].due == cyc);
    if (hit) e = q8.pop_front();
    check_out(0, "dut8", ov8, g8, hit, e);
    e = '0;
    hit = (q20.size() > 0) && (q20[0].due == cyc);
    if (hit) e = q20.pop_front();
    check_out(1, "dut20", ov20, g20, hit, e);
    e = '0;
    hit = (q2.size() > 0) && (q2[0].due == cyc);
    if (hit) e = q2.pop_front();
    check_out(2, "dut2", ov2, g2, hit, e);
    if (ov8 === 1'b1) begin
      pulses8++;
      res8.push_back(longint'(g8[0]));
    end
    if (ov20 === 1'b1) res20.push_back(longint'(g20[0]));
  end

  initial begin
    int     k, p0;
    longint want;
`ifdef CHANNEL_ACC_SAT_EN
    sat_en = 1'b1;
`else
    sat_en = 1'b0;
`endif
    rst_n = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; din = '0;
    model_clear();
    #2;
    check_zero("reset_state");

    // {v, f, l, kind, val, chk, lane0 result of the default instance}
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 0, 1,    1'b1, 64'sd8};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 0, 1,    1'b1, 64'sd8};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1, 1,    1'b0, 64'sd0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1, 2,    1'b0, 64'sd0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 0, 77,   1'b0, 64'sd0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1, 3,    1'b1, 64'sd48};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 2, 100,  1'b1, 64'sd0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 0, -5,   1'b1, -64'sd40};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 0, 1,    1'b0, 64'sd0};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 0, 1,    1'b1, -64'sd24};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 0, 3,    1'b1, 64'sd24};

    for (int i = 0; i < 11; i++) beat(tbl[i].v, tbl[i].f, tbl[i].l, mk(tbl[i].kind, tbl[i].val));
    idle(12);
    k = 0;
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].chk) begin
        total++;
        if (k >= res8.size()) begin
          bad++; $display("FAIL table%0d result missing got=none want=%0d", i, tbl[i].exp);
        end else if (res8[k] != tbl[i].exp) begin
          bad++; $display("FAIL table%0d lane0 got=%0d want=%0d", i, res8[k], tbl[i].exp);
        end
        k++;
      end
    end

    // Overflow of the 20-bit accumulator: 4 beats of 8*32767 per lane.
    res20.delete();
    beat(1'b1, 1'b1, 1'b0, mk(0, 32767));
    beat(1'b1, 1'b0, 1'b0, mk(0, 32767));
    beat(1'b1, 1'b0, 1'b0, mk(0, 32767));
    beat(1'b1, 1'b0, 1'b1, mk(0, 32767));
    idle(12);
`ifdef CHANNEL_ACC_SAT_EN
    want = 524287;
`else
    want = -32;
`endif
    total++;
    if (res20.size() != 1 || res20[0] != want) begin
      bad++;
      $display("FAIL w20_overflow got=%0d (n=%0d) want=%0d",
               (res20.size() > 0) ? res20[0] : 0, res20.size(), want);
    end

    // Reset in the middle of a group discards it.
    beat(1'b1, 1'b1, 1'b0, mk(0, 1));
    beat(1'b1, 1'b0, 1'b0, mk(0, 1));
    do_reset();
    p0 = pulses8;
    beat(1'b1, 1'b1, 1'b1, mk(0, 2));
    idle(12);
    total++;
    if (pulses8 - p0 != 1 || res8[$] != 16) begin
      bad++; $display("FAIL reset_group pulses got=%0d want=1 lane0 got=%0d want=16",
                      pulses8 - p0, res8[$]);
    end

    // Back-to-back single-beat groups.
    for (int i = 0; i < 4; i++) beat(1'b1, 1'b1, 1'b1, rnd_data());
    idle(4);

    for (int i = 0; i < 400; i++) begin
      beat(($urandom_range(3, 0) != 0), ($urandom_range(4, 0) == 0),
           ($urandom_range(4, 0) == 0), rnd_data());
    end
    idle(12);

    total++;
    if (q8.size() != 0 || q20.size() != 0 || q2.size() != 0) begin
      bad++; $display("FAIL drain pending got=%0d/%0d/%0d want=0/0/0",
                      q8.size(), q20.size(), q2.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
